// File: rtl/types_pkg.sv
// Shared types and helpers for the out-of-order core: ROB entry layout, ROB
// geometry constants and the age function used by every flush path.
package types_pkg;

    localparam int unsigned ROB_DEPTH  = 32;
    localparam int unsigned ROB_TAG_W  = 5;
    localparam int unsigned ROB_PREG_W = 7;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [ROB_PREG_W-1:0] pd_new;
        logic [ROB_PREG_W-1:0] pd_old;
        logic [31:0]           pc;
    } rob_entry_t;

    // Distance of tag from head in program order; wraps naturally since DEPTH is 2**TAG_W.
    function automatic logic [ROB_TAG_W-1:0] rob_age(input logic [ROB_TAG_W-1:0] tag,
                                                     input logic [ROB_TAG_W-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: one allocation and one commit per cycle, three
// completion ports, and squash of everything younger than a mispredicted branch.
module reorder_buffer
    import types_pkg::*;
#(
    parameter int unsigned DEPTH  = ROB_DEPTH,
    parameter int unsigned TAG_W  = ROB_TAG_W,
    parameter int unsigned PREG_W = ROB_PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rob_we_in,
    input  logic [PREG_W-1:0] rob_pd_new_in,
    input  logic [PREG_W-1:0] rob_pd_old_in,
    input  logic [31:0]       rob_pc_in,
    output logic [TAG_W-1:0]  rob_tag_out,
    output logic              rob_full_out,
    output logic [TAG_W-1:0]  curr_rob_tag,
    input  logic              cmpl1_valid,
    input  logic [TAG_W-1:0]  cmpl1_tag,
    input  logic              cmpl2_valid,
    input  logic [TAG_W-1:0]  cmpl2_tag,
    input  logic              cmpl3_valid,
    input  logic [TAG_W-1:0]  cmpl3_tag,
    input  logic              mispredict,
    input  logic [TAG_W-1:0]  mispredict_tag,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic              commit_free_valid,
    output logic [31:0]       commit_pc
);

    localparam logic [TAG_W:0] DepthCnt = (TAG_W+1)'(DEPTH);

    rob_entry_t         entries_q [DEPTH];
    rob_entry_t         entries_d [DEPTH];
    logic [TAG_W-1:0]   head_q, head_d;
    logic [TAG_W-1:0]   tail_q, tail_d;
    logic [TAG_W:0]     count_q, count_d;
    logic               full_q, full_d;

    logic               alloc;
    logic               flush;
    logic [TAG_W-1:0]   flush_off;
    logic [DEPTH-1:0]   squash;
    logic [2:0]         cmpl_valid;
    logic [TAG_W-1:0]   cmpl_tag [3];

    assign cmpl_valid = {cmpl3_valid, cmpl2_valid, cmpl1_valid};
    assign cmpl_tag[0] = cmpl1_tag;
    assign cmpl_tag[1] = cmpl2_tag;
    assign cmpl_tag[2] = cmpl3_tag;

    // Control decode: allocate, commit, flush and which entries the flush kills.
    always_comb begin
        alloc        = rob_we_in && !full_q && !mispredict;
        commit_valid = entries_q[head_q].valid && entries_q[head_q].done;
        flush        = mispredict && entries_q[mispredict_tag].valid;
        flush_off    = TAG_W'(rob_age(ROB_TAG_W'(mispredict_tag), ROB_TAG_W'(head_q)));
        squash       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            squash[i] = flush &&
                (TAG_W'(rob_age(ROB_TAG_W'(i), ROB_TAG_W'(head_q))) > flush_off);
        end
    end

    // Entry array next state: completions, then commit, squash and allocation.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_d[i] = entries_q[i];
        end
        for (int p = 0; p < 3; p++) begin
            if (cmpl_valid[p] && entries_q[cmpl_tag[p]].valid && !squash[cmpl_tag[p]]) begin
                entries_d[cmpl_tag[p]].done = 1'b1;
            end
        end
        if (commit_valid) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].done  = 1'b0;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (squash[i]) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
        end
        // Never collides with the head: the tail slot is free whenever alloc is allowed.
        if (alloc) begin
            entries_d[tail_q].valid  = 1'b1;
            entries_d[tail_q].done   = 1'b0;
            entries_d[tail_q].pd_new = rob_pd_new_in;
            entries_d[tail_q].pd_old = rob_pd_old_in;
            entries_d[tail_q].pc     = rob_pc_in;
        end
    end

    // Pointer and occupancy next state; a flush rebuilds count from the branch offset.
    always_comb begin
        head_d = head_q + TAG_W'(commit_valid);
        if (flush) begin
            tail_d  = mispredict_tag + TAG_W'(1);
            count_d = (TAG_W+1)'(flush_off) + (TAG_W+1)'(1) - (TAG_W+1)'(commit_valid);
        end else begin
            tail_d  = tail_q + TAG_W'(alloc);
            count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit_valid);
        end
        full_d = (count_d == DepthCnt);
    end

    // State registers; the entry array is flops so reset can clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Outputs: status straight from registers, commit data gated by commit_valid.
    always_comb begin
        rob_tag_out       = tail_q;
        rob_full_out      = full_q;
        curr_rob_tag      = head_q;
        commit_tag        = commit_valid ? head_q : '0;
        commit_pd_new     = commit_valid ? entries_q[head_q].pd_new : '0;
        commit_pd_old     = commit_valid ? entries_q[head_q].pd_old : '0;
        commit_pc         = commit_valid ? entries_q[head_q].pc : '0;
        commit_free_valid = commit_valid && (commit_pd_old != '0);
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/back-pressure, out-of-order completion,
// free-register gating, wrapped flush, full with simultaneous events, async reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rob_we_in;
    logic [6:0]  rob_pd_new_in, rob_pd_old_in;
    logic [31:0] rob_pc_in;
    logic [4:0]  rob_tag_out, curr_rob_tag;
    logic        rob_full_out;
    logic        cmpl1_valid, cmpl2_valid, cmpl3_valid;
    logic [4:0]  cmpl1_tag, cmpl2_tag, cmpl3_tag;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        commit_valid, commit_free_valid;
    logic [4:0]  commit_tag;
    logic [6:0]  commit_pd_new, commit_pd_old;
    logic [31:0] commit_pc;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .rob_we_in         (rob_we_in),
        .rob_pd_new_in     (rob_pd_new_in),
        .rob_pd_old_in     (rob_pd_old_in),
        .rob_pc_in         (rob_pc_in),
        .rob_tag_out       (rob_tag_out),
        .rob_full_out      (rob_full_out),
        .curr_rob_tag      (curr_rob_tag),
        .cmpl1_valid       (cmpl1_valid),
        .cmpl1_tag         (cmpl1_tag),
        .cmpl2_valid       (cmpl2_valid),
        .cmpl2_tag         (cmpl2_tag),
        .cmpl3_valid       (cmpl3_valid),
        .cmpl3_tag         (cmpl3_tag),
        .mispredict        (mispredict),
        .mispredict_tag    (mispredict_tag),
        .commit_valid      (commit_valid),
        .commit_tag        (commit_tag),
        .commit_pd_new     (commit_pd_new),
        .commit_pd_old     (commit_pd_old),
        .commit_free_valid (commit_free_valid),
        .commit_pc         (commit_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_we_in      = 1'b0;
        rob_pd_new_in  = '0;
        rob_pd_old_in  = '0;
        rob_pc_in      = '0;
        cmpl1_valid    = 1'b0;
        cmpl2_valid    = 1'b0;
        cmpl3_valid    = 1'b0;
        cmpl1_tag      = '0;
        cmpl2_tag      = '0;
        cmpl3_tag      = '0;
        mispredict     = 1'b0;
        mispredict_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic [6:0] pdn, input logic [6:0] pdo, input logic [31:0] pc);
        rob_we_in     = 1'b1;
        rob_pd_new_in = pdn;
        rob_pd_old_in = pdo;
        rob_pc_in     = pc;
        tick();
        rob_we_in     = 1'b0;
    endtask

    // Allocate n entries while completing each one a cycle later, so head ends at n.
    task automatic advance_head(input int n);
        for (int k = 0; k <= n; k++) begin
            rob_we_in     = (k < n);
            rob_pd_new_in = 7'(k + 1);
            rob_pd_old_in = 7'(k + 2);
            rob_pc_in     = 32'h100 + 32'(4 * k);
            cmpl1_valid   = (k > 0);
            cmpl1_tag     = 5'(k - 1);
            tick();
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        do_reset();

        // Reset state
        check_eq("rst_tag_out", rob_tag_out, 0);
        check_eq("rst_head", curr_rob_tag, 0);
        check_eq("rst_full", rob_full_out, 0);
        check_eq("rst_commit_valid", commit_valid, 0);
        check_eq("rst_free_valid", commit_free_valid, 0);
        check_eq("rst_commit_pc", commit_pc, 0);

        // Fill and back-pressure
        for (int i = 0; i < 32; i++) begin
            check_eq("fill_tag", rob_tag_out, 64'(i));
            alloc(7'(i + 1), 7'(i), 32'h100 + 32'(4 * i));
        end
        check_eq("fill_full", rob_full_out, 1);
        check_eq("fill_tag_wrap", rob_tag_out, 0);
        check_eq("fill_count", dut.count_q, 32);
        alloc(7'd99, 7'd98, 32'hdead);
        check_eq("fill_33_count", dut.count_q, 32);
        check_eq("fill_33_full", rob_full_out, 1);
        check_eq("fill_33_tag", rob_tag_out, 0);
        check_eq("fill_no_commit", commit_valid, 0);

        // Out-of-order completion
        do_reset();
        for (int i = 0; i < 3; i++) alloc(7'(10 + i), 7'(20 + i), 32'h200 + 32'(4 * i));
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd2; tick(); idle();
        check_eq("ooo_wait_a", commit_valid, 0);
        cmpl2_valid = 1'b1; cmpl2_tag = 5'd1; tick(); idle();
        check_eq("ooo_wait_b", commit_valid, 0);
        cmpl3_valid = 1'b1; cmpl3_tag = 5'd0; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            check_eq("ooo_commit_valid", commit_valid, 1);
            check_eq("ooo_commit_tag", commit_tag, 64'(i));
            check_eq("ooo_commit_pc", commit_pc, 64'(32'h200 + 32'(4 * i)));
            tick();
        end
        check_eq("ooo_drained", commit_valid, 0);
        check_eq("ooo_head", curr_rob_tag, 3);

        // Free-register gating
        do_reset();
        alloc(7'd10, 7'd0, 32'h300);
        alloc(7'd11, 7'd45, 32'h304);
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd0;
        cmpl2_valid = 1'b1; cmpl2_tag = 5'd1;
        tick(); idle();
        check_eq("free0_valid", commit_valid, 1);
        check_eq("free0_tag", commit_tag, 0);
        check_eq("free0_free", commit_free_valid, 0);
        tick();
        check_eq("free1_tag", commit_tag, 1);
        check_eq("free1_free", commit_free_valid, 1);
        check_eq("free1_pd_old", commit_pd_old, 45);
        check_eq("free1_pd_new", commit_pd_new, 11);

        // Wrapped flush
        do_reset();
        advance_head(28);
        check_eq("wrap_head", curr_rob_tag, 28);
        check_eq("wrap_empty", dut.count_q, 0);
        for (int j = 0; j < 10; j++) alloc(7'(j), 7'(j + 1), 32'h400 + 32'(4 * j));
        check_eq("wrap_count10", dut.count_q, 10);
        check_eq("wrap_tail6", rob_tag_out, 6);
        mispredict = 1'b1; mispredict_tag = 5'd30; tick(); idle();
        check_eq("flush_tail", rob_tag_out, 31);
        check_eq("flush_count", dut.count_q, 3);
        check_eq("flush_head", curr_rob_tag, 28);
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd2;
        cmpl2_valid = 1'b1; cmpl2_tag = 5'd31;
        tick(); idle();
        check_eq("flush_dead_cmpl", commit_valid, 0);
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd28;
        cmpl2_valid = 1'b1; cmpl2_tag = 5'd29;
        cmpl3_valid = 1'b1; cmpl3_tag = 5'd30;
        tick(); idle();
        for (int t = 28; t <= 30; t++) begin
            check_eq("flush_commit_tag", commit_tag, 64'(t));
            tick();
        end
        check_eq("flush_drained", commit_valid, 0);
        check_eq("flush_count0", dut.count_q, 0);
        check_eq("flush_head31", curr_rob_tag, 31);
        alloc(7'd5, 7'd6, 32'h500);
        tick();
        check_eq("flush_realloc_not_done", commit_valid, 0);
        check_eq("flush_realloc_count", dut.count_q, 1);

        // Full with simultaneous alloc and commit
        do_reset();
        advance_head(5);
        check_eq("full_head5", curr_rob_tag, 5);
        for (int j = 0; j < 32; j++) alloc(7'(j), 7'(j + 3), 32'h600 + 32'(4 * j));
        check_eq("full_full", rob_full_out, 1);
        check_eq("full_count", dut.count_q, 32);
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd5;
        cmpl2_valid = 1'b1; cmpl2_tag = 5'd6;
        tick(); idle();
        check_eq("full_commit5", commit_tag, 5);
        alloc(7'd1, 7'd2, 32'h700);
        check_eq("full_drop_count", dut.count_q, 31);
        check_eq("full_drop_tail", rob_tag_out, 5);
        check_eq("full_drop_notfull", rob_full_out, 0);
        check_eq("full_commit6", commit_tag, 6);
        alloc(7'd1, 7'd2, 32'h704);
        check_eq("full_both_count", dut.count_q, 31);
        check_eq("full_both_tail", rob_tag_out, 6);
        check_eq("full_both_head", curr_rob_tag, 7);

        // Asynchronous reset mid-run
        do_reset();
        for (int j = 0; j < 12; j++) alloc(7'(j), 7'(j + 1), 32'h800 + 32'(4 * j));
        cmpl1_valid = 1'b1; cmpl1_tag = 5'd0; tick(); idle();
        check_eq("ar_pre_count", dut.count_q, 12);
        check_eq("ar_pre_commit", commit_valid, 1);
        check_eq("ar_pre_pc", commit_pc, 32'h800);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_tag_out", rob_tag_out, 0);
        check_eq("ar_head", curr_rob_tag, 0);
        check_eq("ar_full", rob_full_out, 0);
        check_eq("ar_commit", commit_valid, 0);
        check_eq("ar_pc", commit_pc, 0);
        check_eq("ar_count", dut.count_q, 0);
        #2 reset = 1'b1;
        tick();
        check_eq("ar_first_tag", rob_tag_out, 0);
        alloc(7'd3, 7'd4, 32'h900);
        check_eq("ar_next_tag", rob_tag_out, 1);
        check_eq("ar_count1", dut.count_q, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
